// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and state types plus width limits for alu_seq_core
package alu_seq_pkg;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_ACC = 3'd6,
    OP_CLR = 3'd7
  } alu_op_e;
  typedef enum logic {ST_IDLE, ST_MUL} alu_state_e;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-cycle shift-add unsigned multiplier with start/done
module alu_mul_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  logic             busy;
  logic [CW-1:0]    step;
  logic [W2-1:0]    mcand;
  logic [W2-1:0]    part;
  logic [WIDTH-1:0] mplier;
  assign product = part + (mplier[0] ? mcand : '0);
  assign done    = busy && step == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      step   <= '0;
      mcand  <= '0;
      mplier <= '0;
      part   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      step   <= '0;
      mcand  <= W2'(a);
      mplier <= b;
      part   <= '0;
    end else if (busy) begin
      part   <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= done ? '0 : step + 1'b1;
      busy   <= !done;
    end
  end
endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked ALU with accumulator, sequential multiply and one-deep output register
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero
);
  localparam int W2 = 2 * WIDTH;
  alu_state_e    state;
  alu_op_e       op_e;
  logic [W2-1:0] acc;
  logic [WIDTH:0] add_s;
  logic [WIDTH:0] sub_s;
  logic [W2:0]   acc_s;
  logic [W2-1:0] res_c;
  logic          cy_c;
  logic [W2-1:0] mul_p;
  logic [W2-1:0] ld_res;
  logic          ld_cy;
  logic          accept;
  logic          mul_start;
  logic          mul_done;
  logic          load;
  assign op_e      = alu_op_e'(op);
  assign in_ready  = state == ST_IDLE && (!out_valid || out_ready) && !rst;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && op_e == OP_MUL;
  assign load      = (accept && op_e != OP_MUL) || mul_done;
  assign ld_res    = mul_done ? mul_p : res_c;
  assign ld_cy     = mul_done ? 1'b0 : cy_c;
  always_comb begin
    add_s = {1'b0, a} + {1'b0, b};
    sub_s = {1'b0, a} - {1'b0, b};
    acc_s = {1'b0, acc} + (W2 + 1)'(a);
    res_c = op_e == OP_ADD ? W2'(add_s) :
            op_e == OP_SUB ? W2'(sub_s[WIDTH-1:0]) :
            op_e == OP_AND ? W2'(a & b) :
            op_e == OP_OR  ? W2'(a | b) :
            op_e == OP_XOR ? W2'(a ^ b) :
            op_e == OP_ACC ? acc_s[W2-1:0] : '0;
    cy_c  = op_e == OP_ADD ? add_s[WIDTH] :
            op_e == OP_SUB ? sub_s[WIDTH] :
            op_e == OP_ACC ? acc_s[W2] : 1'b0;
  end
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_p)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
    end else begin
      state <= state == ST_IDLE ? (mul_start ? ST_MUL : ST_IDLE) : (mul_done ? ST_IDLE : ST_MUL);
      if (accept && op_e == OP_ACC) acc <= acc_s[W2-1:0];
      else if (accept && op_e == OP_CLR) acc <= '0;
      if (load) begin
        out_valid <= 1'b1;
        result    <= ld_res;
        carry     <= ld_cy;
        zero      <= ld_res == '0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
